// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Counter width for a count that must reach n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_TICK_W = cnt_w(DEF_OVERSAMPLE);
    localparam int DEF_BIT_W  = cnt_w(DEF_DATA_BITS + 1);

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous level input; resets to RST_VAL.
module uart_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start qualification, mid-bit sampling, shift/FIFO
// strobes and sticky framing/parity/overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic rx,
    input  logic rx_en,
    input  logic fifo_full,
    input  logic err_clr,
    output logic shift_en,
    output logic sample_bit,
    output logic fifo_wr,
    output logic frame_err,
    output logic parity_err,
    output logic overrun_err,
    output logic busy
);

    localparam int TICK_W = cnt_w(OVERSAMPLE);
    localparam int BIT_W  = cnt_w(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);

    logic rx_s;

    rx_state_t         state_reg, state_next;
    logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              parity_reg, parity_next;
    logic              frame_err_reg, parity_err_reg, overrun_err_reg;

    logic shift_c, wr_c, set_frame, set_parity, set_overrun;

    uart_rx_sync #(
        .STAGES  (2),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx),
        .sync_out (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            tick_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            parity_reg      <= 1'b0;
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            overrun_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tick_cnt_reg    <= tick_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            parity_reg      <= parity_next;
            // A set event in the same cycle as err_clr keeps the flag set.
            frame_err_reg   <= set_frame   | (frame_err_reg   & ~err_clr);
            parity_err_reg  <= set_parity  | (parity_err_reg  & ~err_clr);
            overrun_err_reg <= set_overrun | (overrun_err_reg & ~err_clr);
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        parity_next   = parity_reg;
        shift_c       = 1'b0;
        wr_c          = 1'b0;
        set_frame     = 1'b0;
        set_parity    = 1'b0;
        set_overrun   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (tick && rx_en && !rx_s) begin
                    state_next    = START;
                    tick_cnt_next = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_reg == HALF_LAST) begin
                        tick_cnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                            parity_next  = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_LAST) begin
                        shift_c       = 1'b1;
                        parity_next   = parity_reg ^ rx_s;
                        bit_cnt_next  = bit_cnt_reg + BIT_W'(1);
                        tick_cnt_next = '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_LAST) begin
                        set_parity    = (rx_s != (parity_reg ^ ODD_BIT));
                        tick_cnt_next = '0;
                        state_next    = STOP;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_reg == FULL_LAST) begin
                        tick_cnt_next = '0;
                        if (!rx_s) begin
                            set_frame  = 1'b1;
                            state_next = WAIT_IDLE;
                        end else if (fifo_full) begin
                            set_overrun = 1'b1;
                            state_next  = IDLE;
                        end else begin
                            wr_c       = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TICK_W'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                // Holds off a break (line stuck low) from retriggering frames.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next    = IDLE;
                tick_cnt_next = '0;
            end
        endcase
    end

    assign shift_en    = shift_c & ~rst;
    assign sample_bit  = shift_c & ~rst & rx_s;
    assign fifo_wr     = wr_c & ~rst;
    assign frame_err   = frame_err_reg;
    assign parity_err  = parity_err_reg;
    assign overrun_err = overrun_err_reg;
    assign busy        = (state_reg != IDLE);

endmodule
